ls_issue_queue: RTL

In-order issue queue directly upstream of the load/store wrapper. It accepts dispatched load/store instructions whose base (A) and store-data (B) operands may still be pending. It captures those operands from the writeback bus by ROB tag. It presents the oldest entry to the load/store wrapper only once both operands are present, so memory operations leave the queue strictly in program order.

---
 rtl/ls_issue_queue_pkg.sv | 42 ++++
 rtl/lsq_operand.sv | 56 +++++
 rtl/ls_issue_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ls_issue_queue_pkg.sv
// rtl/ls_issue_queue_pkg.sv - shared types and constants for the load/store issue queue
//
// Contents: ROB_TAG_W, XLEN, dec_inst_t (decoded load/store), lsq_entry_t (one
// queue slot), tag_hit() writeback/tag compare helper.
package ls_issue_queue_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int XLEN      = 32;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } ls_size_e;

    typedef struct packed {
        logic        is_store;
        ls_size_e    size;
        logic        sign_ext;
        logic [11:0] imm;
    } dec_inst_t;

    typedef struct packed {
        logic                 valid;
        dec_inst_t            inst;
        logic [ROB_TAG_W-1:0] rob_slot;
        logic [XLEN-1:0]      a_val;
        logic                 a_rdy;
        logic [ROB_TAG_W-1:0] a_tag;
        logic [XLEN-1:0]      b_val;
        logic                 b_rdy;
        logic [ROB_TAG_W-1:0] b_tag;
    } lsq_entry_t;

    function automatic logic tag_hit(input logic                 wb_valid,
                                     input logic [ROB_TAG_W-1:0] wb_idx,
                                     input logic [ROB_TAG_W-1:0] tag);
        return wb_valid && (wb_idx == tag);
    endfunction

endpackage

// File: rtl/lsq_operand.sv
// rtl/lsq_operand.sv - next-state logic for one operand slot (capture on enqueue, wakeup by ROB tag)
//
// Ports:
//   entry_valid_i            owning entry currently holds an instruction
//   cur_val_i/rdy_i/tag_i    stored operand state
//   load_i                   entry is being written by an enqueue this cycle
//   enq_val_i/rdy_i/tag_i    operand presented by dispatch
//   wb_valid_i/idx_i/data_i  writeback bus
//   nxt_val_o/rdy_o/tag_o    operand state to store at the next edge
//   hit_o                    stored operand is pending and matches the writeback now
module lsq_operand
    import ls_issue_queue_pkg::*;
(
    input  logic                 entry_valid_i,
    input  logic [XLEN-1:0]      cur_val_i,
    input  logic                 cur_rdy_i,
    input  logic [ROB_TAG_W-1:0] cur_tag_i,
    input  logic                 load_i,
    input  logic [XLEN-1:0]      enq_val_i,
    input  logic                 enq_rdy_i,
    input  logic [ROB_TAG_W-1:0] enq_tag_i,
    input  logic                 wb_valid_i,
    input  logic [ROB_TAG_W-1:0] wb_idx_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic [XLEN-1:0]      nxt_val_o,
    output logic                 nxt_rdy_o,
    output logic [ROB_TAG_W-1:0] nxt_tag_o,
    output logic                 hit_o
);

    assign hit_o = entry_valid_i && !cur_rdy_i && tag_hit(wb_valid_i, wb_idx_i, cur_tag_i);

    always_comb begin
        nxt_val_o = cur_val_i;
        nxt_rdy_o = cur_rdy_i;
        nxt_tag_o = cur_tag_i;
        if (load_i) begin
            nxt_tag_o = enq_tag_i;
            if (enq_rdy_i) begin
                nxt_val_o = enq_val_i;
                nxt_rdy_o = 1'b1;
            end else if (tag_hit(wb_valid_i, wb_idx_i, enq_tag_i)) begin
                // producer writes back in the very cycle we are dispatched
                nxt_val_o = wb_data_i;
                nxt_rdy_o = 1'b1;
            end else begin
                nxt_val_o = enq_val_i;
                nxt_rdy_o = 1'b0;
            end
        end else if (hit_o) begin
            nxt_val_o = wb_data_i;
            nxt_rdy_o = 1'b1;
        end
    end

endmodule

// File: rtl/ls_issue_queue.sv
// rtl/ls_issue_queue.sv - in-order load/store issue queue with operand wakeup from the writeback bus
//
// Optional feature macro: LSQ_ISSUE_BYPASS_EN (head may issue using the current writeback).
// Ports:
//   clock, reset_n (async active-low), flush
//   enq_valid/enq_ready, enq_inst, enq_rob_slot, enq_A/B, enq_A/B_valid, enq_A/B_tag
//   wb_valid, wb_idx, wb_data                 writeback bus
//   inst, inst_valid, A, B, rob_slot, ls_ready  issue port to the LS wrapper
//   count                                     occupied entries
module ls_issue_queue
    import ls_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  dec_inst_t             enq_inst,
    input  logic [ROB_TAG_W-1:0]  enq_rob_slot,
    input  logic [XLEN-1:0]       enq_A,
    input  logic [XLEN-1:0]       enq_B,
    input  logic                  enq_A_valid,
    input  logic                  enq_B_valid,
    input  logic [ROB_TAG_W-1:0]  enq_A_tag,
    input  logic [ROB_TAG_W-1:0]  enq_B_tag,
    input  logic                  wb_valid,
    input  logic [ROB_TAG_W-1:0]  wb_idx,
    input  logic [XLEN-1:0]       wb_data,
    output dec_inst_t             inst,
    output logic                  inst_valid,
    output logic [XLEN-1:0]       A,
    output logic [XLEN-1:0]       B,
    output logic [ROB_TAG_W-1:0]  rob_slot,
    input  logic                  ls_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

`ifdef LSQ_ISSUE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    lsq_entry_t        entries_q [DEPTH];
    lsq_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0]  head_idx, tail_idx;
    lsq_entry_t        head_e;
    logic              full, enq_fire, a_ok, b_ok, a_byp, b_byp;

    logic [DEPTH-1:0]     load_en, a_rdy_n, b_rdy_n, a_hit, b_hit;
    logic [XLEN-1:0]      a_val_n [DEPTH];
    logic [XLEN-1:0]      b_val_n [DEPTH];
    logic [ROB_TAG_W-1:0] a_tag_n [DEPTH];
    logic [ROB_TAG_W-1:0] b_tag_n [DEPTH];

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && !full && !flush;
    assign count     = tail_q - head_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign load_en[i] = enq_fire && (tail_idx == IDX_W'(i));

        lsq_operand u_op_a (
            .entry_valid_i (entries_q[i].valid),
            .cur_val_i     (entries_q[i].a_val),
            .cur_rdy_i     (entries_q[i].a_rdy),
            .cur_tag_i     (entries_q[i].a_tag),
            .load_i        (load_en[i]),
            .enq_val_i     (enq_A),
            .enq_rdy_i     (enq_A_valid),
            .enq_tag_i     (enq_A_tag),
            .wb_valid_i    (wb_valid),
            .wb_idx_i      (wb_idx),
            .wb_data_i     (wb_data),
            .nxt_val_o     (a_val_n[i]),
            .nxt_rdy_o     (a_rdy_n[i]),
            .nxt_tag_o     (a_tag_n[i]),
            .hit_o         (a_hit[i])
        );

        lsq_operand u_op_b (
            .entry_valid_i (entries_q[i].valid),
            .cur_val_i     (entries_q[i].b_val),
            .cur_rdy_i     (entries_q[i].b_rdy),
            .cur_tag_i     (entries_q[i].b_tag),
            .load_i        (load_en[i]),
            .enq_val_i     (enq_B),
            .enq_rdy_i     (enq_B_valid),
            .enq_tag_i     (enq_B_tag),
            .wb_valid_i    (wb_valid),
            .wb_idx_i      (wb_idx),
            .wb_data_i     (wb_data),
            .nxt_val_o     (b_val_n[i]),
            .nxt_rdy_o     (b_rdy_n[i]),
            .nxt_tag_o     (b_tag_n[i]),
            .hit_o         (b_hit[i])
        );
    end

    // Issue side: outputs always mirror the head; inst_valid is the only qualifier.
    assign head_e     = entries_q[head_idx];
    assign a_byp      = BYPASS && a_hit[head_idx];
    assign b_byp      = BYPASS && b_hit[head_idx];
    assign a_ok       = head_e.a_rdy || a_byp;
    assign b_ok       = head_e.b_rdy || b_byp;
    assign inst_valid = head_e.valid && a_ok && b_ok && ls_ready && !flush;
    assign inst       = head_e.inst;
    assign rob_slot   = head_e.rob_slot;
    assign A          = a_byp ? wb_data : head_e.a_val;
    assign B          = b_byp ? wb_data : head_e.b_val;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i]       = entries_q[i];
            entries_d[i].a_val = a_val_n[i];
            entries_d[i].a_rdy = a_rdy_n[i];
            entries_d[i].a_tag = a_tag_n[i];
            entries_d[i].b_val = b_val_n[i];
            entries_d[i].b_rdy = b_rdy_n[i];
            entries_d[i].b_tag = b_tag_n[i];
            if (load_en[i]) begin
                entries_d[i].valid    = 1'b1;
                entries_d[i].inst     = enq_inst;
                entries_d[i].rob_slot = enq_rob_slot;
            end
        end
        // Head and tail slots never coincide while both an issue and an
        // enqueue fire: a full queue blocks enqueue, an empty one cannot issue.
        if (inst_valid) begin
            entries_d[head_idx].valid = 1'b0;
            head_d = head_q + PTR_W'(1);
        end
        if (enq_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule
